gelato_fetch_scheduler: RTL
===========================

// Module: gelato_fetch_scheduler
// PURPOSE
// - Consumer end of the gelato_pctable_fetchskd interface: takes per-warp PC/valid/split-table number from the split table.
// - Picks one eligible warp per cycle, round-robin, and issues a fetch request to the instruction fetch stage.
// - Blocks a warp after issue until the decode/split path re-arms it (activate_valid/activate_warp_num).
// - Guarantees at most one instruction in flight per warp.
// PARAMETERS
// - WARP_NUM       8   number of warps; power of two, >=2
// - ADDR_WIDTH     32  PC width
// - SPLIT_W        4   split_table_num width
// PORTS
// - clk                 in   1                  clock
// - rst_n               in   1                  asynchronous active-low reset
// - rdy                 in   1                  global enable; 0 freezes all state
// - pct_valid           in   WARP_NUM           per-warp PC valid from split table
// - pct_pc              in   WARP_NUM*ADDR_WIDTH  per-warp PC, warp i at [i*ADDR_WIDTH +: ADDR_WIDTH]
// - pct_split_num       in   WARP_NUM*SPLIT_W   per-warp split table number
// - activate_valid      in   1                  re-arm pulse for one warp
// - activate_warp_num   in   log2(WARP_NUM)     warp to re-arm
// - fetch_valid         out  1                  fetch request valid
// - fetch_ready         in   1                  fetch stage accepts request
// - fetch_warp_num      out  log2(WARP_NUM)     issuing warp
// - fetch_pc            out  ADDR_WIDTH         PC to fetch
// - fetch_split_num     out  SPLIT_W            split entry the PC came from
// - inflight_cnt        out  log2(WARP_NUM)+1   number of warps in WAIT state
// BEHAVIOUR
// - Per-warp state: READY / WAIT (1 bit each). Reset: all READY.
// - Reset values: fetch_valid=0, fetch_warp_num=0, fetch_pc=0, fetch_split_num=0, inflight_cnt=0, rr pointer=0.
// - Eligibility: eligible[i] = pct_valid[i] & state[i]==READY.
// - Selection: combinational round-robin over eligible, starting at rr_ptr. Search order is rr_ptr, rr_ptr+1, ... with wrap-around modulo WARP_NUM.
// - Output register: loads selected warp when (!fetch_valid | fetch_ready) & any eligible & rdy.
//   - Loaded warp goes WAIT in the same edge.
//   - rr_ptr <= selected+1 (wraps to 0).
//   - Latency: eligible warp -> fetch_valid one cycle later.
// - Handshake (valid/ready):
//   - Payload is held stable while fetch_valid & !fetch_ready.
//   - Deassertion of pct_valid for the held warp does not cancel the request.
//   - fetch_ready with fetch_valid=0 is ignored.
// - Back-to-back: handshake and load of the next warp occur in the same cycle; fetch_valid stays 1. No eligible warp at handshake -> fetch_valid <= 0.
// - Activate: activate_valid & rdy sets state[activate_warp_num] to READY.
//   - The warp becomes eligible the next cycle, i.e. re-issue no earlier than 2 cycles after activate.
//   - Activate for a warp already READY is ignored (no count change).
// - Simultaneous activate(w) and load(v):
//   - Both apply.
//   - If w==v, the load wins: v goes WAIT. This is legal only as a protocol error; the verifier flags it.
// - inflight_cnt: +1 on load, -1 on an effective activate; both in one cycle -> unchanged. Never exceeds WARP_NUM.
// - rdy=0: no state, counter, pointer or output register change. fetch_valid holds its value and fetch_ready is ignored.
// - Async reset mid-request drops fetch_valid immediately; all warps return to READY.
// STRUCTURE
// - Shared package gelato_types: warp_num_t, addr_t, split_table_num_t, enum warp_skd_state_t {SKD_READY, SKD_WAIT}.
// - Sub-module gelato_rr_arbiter (WARP_NUM req, base pointer -> one-hot grant + index + any).
//   - Purely combinational; reused later by the issue stage.
// - Top holds the state vector, rr pointer, output register and counter.
// TESTING
// - Reset, all pct_valid=0 -> fetch_valid=0 forever, inflight_cnt=0.
// - pct_valid=8'hFF, fetch_ready=1, no activate:
//   - warps 0..7 issue on consecutive cycles 1..8, then fetch_valid=0, inflight_cnt=8.
// - Warp 3 only valid, pc=32'h100, fetch_ready=0 for 5 cycles:
//   - payload (3, 32'h100) held stable for 5 cycles, then issued once.
//   - warp 3 is not re-selected afterwards.
// - Warps 2 and 5 in WAIT, activate 5:
//   - warp 5 issues 2 cycles later, before warp 2.
//   - Activating warp 5 again while READY leaves inflight_cnt unchanged.
// - Issue, then rdy=0 for 4 cycles with fetch_ready=1:
//   - no handshake, no state change; resumes exactly where it stopped when rdy=1.
// - Assert rst_n=0 while fetch_valid=1 with 4 warps WAIT:
//   - outputs zero asynchronously; after release all warps eligible again, warp 0 first.

Source files
------------

// File: rtl/gelato_types_pkg.sv
// Shared types for the gelato front end: warp/PC/split-table widths and the
// per-warp fetch scheduling state.
package gelato_types;

  localparam int WARP_NUM_DEF   = 8;
  localparam int ADDR_WIDTH_DEF = 32;
  localparam int SPLIT_W_DEF    = 4;

  typedef logic [$clog2(WARP_NUM_DEF)-1:0] warp_num_t;
  typedef logic [ADDR_WIDTH_DEF-1:0]       addr_t;
  typedef logic [SPLIT_W_DEF-1:0]          split_table_num_t;

  typedef enum logic {
    SKD_READY = 1'b0,
    SKD_WAIT  = 1'b1
  } warp_skd_state_t;

endpackage

// File: rtl/gelato_rr_arbiter.sv
// Combinational round-robin arbiter: the first requester at or after base_i
// (wrapping modulo N) wins. N must be a power of two.
module gelato_rr_arbiter #(
  parameter  int N     = 8,
  localparam int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] base_i,
  output logic [N-1:0]     grant_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  logic [IDX_W-1:0] cand;

  // Scan from the farthest offset down so the nearest requester is written last.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    cand    = '0;
    for (int i = N - 1; i >= 0; i--) begin
      cand = base_i + IDX_W'(i);
      if (req_i[cand]) begin
        idx_o = cand;
        any_o = 1'b1;
      end
    end
    if (any_o) grant_o[idx_o] = 1'b1;
  end

endmodule

// File: rtl/gelato_fetch_scheduler.sv
// Fetch scheduler: round-robin picks one READY warp with a valid PC, issues it
// over a valid/ready port and parks it in WAIT until it is re-armed.
module gelato_fetch_scheduler
  import gelato_types::*;
#(
  parameter  int WARP_NUM   = 8,
  parameter  int ADDR_WIDTH = 32,
  parameter  int SPLIT_W    = 4,
  localparam int WN_W       = $clog2(WARP_NUM),
  localparam int CNT_W      = WN_W + 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           rdy,
  input  logic [WARP_NUM-1:0]            pct_valid,
  input  logic [WARP_NUM*ADDR_WIDTH-1:0] pct_pc,
  input  logic [WARP_NUM*SPLIT_W-1:0]    pct_split_num,
  input  logic                           activate_valid,
  input  logic [WN_W-1:0]                activate_warp_num,
  output logic                           fetch_valid,
  input  logic                           fetch_ready,
  output logic [WN_W-1:0]                fetch_warp_num,
  output logic [ADDR_WIDTH-1:0]          fetch_pc,
  output logic [SPLIT_W-1:0]             fetch_split_num,
  output logic [CNT_W-1:0]               inflight_cnt
);

  warp_skd_state_t       state_q [WARP_NUM];
  logic [WN_W-1:0]       rr_ptr_q;
  logic [WARP_NUM-1:0]   eligible;
  logic [WARP_NUM-1:0]   grant;
  logic [WN_W-1:0]       sel_idx;
  logic                  sel_any;
  logic                  out_free;
  logic                  load;
  logic                  act_eff;

  always_comb begin
    eligible = '0;
    for (int i = 0; i < WARP_NUM; i++) begin
      eligible[i] = pct_valid[i] & (state_q[i] == SKD_READY);
    end
  end

  gelato_rr_arbiter #(.N(WARP_NUM)) u_arb (
    .req_i   (eligible),
    .base_i  (rr_ptr_q),
    .grant_o (grant),
    .idx_o   (sel_idx),
    .any_o   (sel_any)
  );

  // The output register may take a new warp when empty or when handing off.
  assign out_free = ~fetch_valid | fetch_ready;
  assign load     = rdy & out_free & sel_any;
  assign act_eff  = rdy & activate_valid & (state_q[activate_warp_num] == SKD_WAIT);

  // NOTE: all state here is flop-based and updated with non-blocking
  // assignments, so every always_ff reads the pre-edge values and the order of
  // statements only matters where the same target is written twice.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WARP_NUM; i++) state_q[i] <= SKD_READY;
      rr_ptr_q        <= '0;
      fetch_valid     <= 1'b0;
      fetch_warp_num  <= '0;
      fetch_pc        <= '0;
      fetch_split_num <= '0;
      inflight_cnt    <= '0;
    end else if (rdy) begin
      if (act_eff) state_q[activate_warp_num] <= SKD_READY;
      // Written after the activate so a same-warp collision leaves it in WAIT.
      for (int i = 0; i < WARP_NUM; i++) begin
        if (load && grant[i]) state_q[i] <= SKD_WAIT;
      end
      if (out_free) fetch_valid <= sel_any;
      if (load) begin
        fetch_warp_num  <= sel_idx;
        fetch_pc        <= pct_pc[sel_idx*ADDR_WIDTH +: ADDR_WIDTH];
        fetch_split_num <= pct_split_num[sel_idx*SPLIT_W +: SPLIT_W];
        rr_ptr_q        <= sel_idx + WN_W'(1);
      end
      case ({load, act_eff})
        2'b10:   inflight_cnt <= inflight_cnt + CNT_W'(1);
        2'b01:   inflight_cnt <= inflight_cnt - CNT_W'(1);
        default: inflight_cnt <= inflight_cnt;
      endcase
    end
  end

endmodule
